wb_cmd_master: RTL and testbench
================================

// Module: wb_cmd_master
// PURPOSE
//  Synthesizable Wishbone classic master command engine. It turns the single
//  start/address/selection/write/data_wr command interface driven by the test
//  tasks into one Wishbone bus cycle on the DSP bus. It returns read data,
//  busy and status, and holds one pending command so the caller can queue
//  the next access.
// PARAMETERS
//  AW       32   address width (wb_adr_o, address)
//  DW       32   data width (wb_dat_o/wb_dat_i, data_wr/data_rd)
//  TIMEOUT  256  max cycles in BUS without ack/err before forced abort; >=2
// PORTS
//  wb_clk     in   1     system clock, all logic on rising edge
//  wb_rst     in   1     synchronous, active-high reset
//  start      in   1     command strobe, one cycle per command
//  address    in   AW    command address
//  selection  in   DW/8  byte selects
//  write      in   1     1=write, 0=read
//  data_wr    in   DW    write data
//  data_rd    out  DW    read data of last successful read
//  active     out  1     engine busy or command pending
//  done       out  1     one-cycle pulse, command finished
//  err        out  1     qualifies done: bus error or timeout
//  overrun    out  1     one-cycle pulse, start dropped (pending slot full)
//  wb_adr_o   out  AW    Wishbone address
//  wb_dat_o   out  DW    Wishbone write data
//  wb_sel_o   out  DW/8  Wishbone byte selects
//  wb_we_o    out  1     Wishbone write enable
//  wb_cyc_o   out  1     Wishbone cycle
//  wb_stb_o   out  1     Wishbone strobe (always equal to wb_cyc_o)
//  wb_dat_i   in   DW    Wishbone read data
//  wb_ack_i   in   1     Wishbone acknowledge
//  wb_err_i   in   1     Wishbone error
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, pending slot empty, timeout counter 0.
//   Reset mid-cycle drops cyc/stb at that edge; pending command is discarded.
//  FSM IDLE -> BUS -> DONE -> (BUS if pending, else IDLE).
//  IDLE: start=1 at edge N latches command; cyc/stb/adr/sel/we/dat valid
//   from cycle N+1. Bus outputs are registered and held constant in BUS.
//  BUS: counter increments each cycle. The edge sampling ack|err|timeout ends
//   the cycle: cyc/stb go 0 after that edge. Go to DONE.
//   - ack: read latches wb_dat_i into data_rd; write leaves data_rd unchanged.
//   - err: err status set; data_rd unchanged. err wins if ack and err coincide.
//   - timeout: counter==TIMEOUT-1 with no ack/err ends the cycle with err status.
//  DONE: exactly one cycle. done=1, err=status, cyc=0 (one idle bus cycle
//   between back-to-back commands). Min latency: start edge -> done = 3 cycles
//   with zero-wait ack.
//  Pending slot (depth 1): start while state!=IDLE and slot empty -> captured.
//   start while slot full -> overrun=1 for one cycle; command dropped; state
//   unaffected. Start in DONE, same cycle pending is consumed -> new command
//   is captured into the freed slot, no overrun.
//  active = (state!=IDLE) | pending_valid; deasserts the cycle after the last done.
//  wb_dat_o driven for reads too (don't care); wb_we_o=0 for reads.
// TESTING
//  1 write 0x0000_0010 data 0xCAFE_F00D sel 0xF, ack after 2 waits ->
//    cyc high 3 cycles, dat/sel/we stable, done=1 err=0 one cycle, active drops.
//  2 read 0x0000_0020, slave returns 0x1234_5678 with 0-wait ack ->
//    data_rd=0x1234_5678 at done, done 3 cycles after start.
//  3 start write then start read next cycle, then third start while both busy ->
//    second runs after DONE (one cyc-low gap), overrun pulses for third.
//  4 read, slave never acks, TIMEOUT=16 -> cyc drops after 16 BUS cycles,
//    done=1 err=1, data_rd keeps previous value.
//  5 ack and err asserted together -> err=1 at done. Separately, wb_rst
//    asserted mid-BUS with pending command -> cyc=0, active=0, no done, pending lost.

Source files
------------

// File: rtl/wb_cmd_master_if.sv
// Wishbone classic bus bundle between the command master and a slave.
// The _o/_i suffixes follow the master's point of view on both modports.
interface wb_cmd_master_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   wb_adr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW/8-1:0] wb_sel_o;
    logic            wb_we_o;
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic [DW-1:0]   wb_dat_i;
    logic            wb_ack_i;
    logic            wb_err_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic master: one bus cycle per command, one-deep pending slot,
// ack/err/timeout termination and a one-cycle done/err status pulse.
module wb_cmd_master #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 256
) (
    input  logic            wb_clk,
    input  logic            wb_rst,
    input  logic            start,
    input  logic [AW-1:0]   address,
    input  logic [DW/8-1:0] selection,
    input  logic            write,
    input  logic [DW-1:0]   data_wr,
    output logic [DW-1:0]   data_rd,
    output logic            active,
    output logic            done,
    output logic            err,
    output logic            overrun,
    wb_cmd_master_if.master wb
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_n;

    logic [AW-1:0]   adr_q,  p_adr;
    logic [DW-1:0]   dat_q,  p_dat;
    logic [DW/8-1:0] sel_q,  p_sel;
    logic            we_q,   p_we;
    logic            cyc_q,  p_valid;
    logic [CW-1:0]   cnt;
    logic            err_q, overrun_q;
    logic [DW-1:0]   rd_q;

    logic launch_slot, launch_cmd, bus_end, timeout;
    logic capture, drop;

    assign timeout = (cnt == CMAX);

    // Next state plus launch/termination strobes for the datapath
    always_comb begin
        state_n     = state;
        launch_slot = 1'b0;
        launch_cmd  = 1'b0;
        bus_end     = 1'b0;
        unique case (state)
            IDLE: begin
                if (p_valid) begin
                    launch_slot = 1'b1;
                    state_n     = BUS;
                end else if (start) begin
                    launch_cmd = 1'b1;
                    state_n    = BUS;
                end
            end
            BUS: begin
                if (wb.wb_ack_i || wb.wb_err_i || timeout) begin
                    bus_end = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                if (p_valid) begin
                    launch_slot = 1'b1;
                    state_n     = BUS;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A start not launched directly fills the slot if it is empty or
    // being vacated this same edge; otherwise it is dropped.
    assign capture = start && !launch_cmd && (!p_valid || launch_slot);
    assign drop    = start && p_valid && !launch_slot;

    // State register
    always_ff @(posedge wb_clk) begin
        if (wb_rst) state <= IDLE;
        else        state <= state_n;
    end

    // Registered bus outputs, timeout counter, status and read data
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            cyc_q     <= 1'b0;
            cnt       <= '0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
            rd_q      <= '0;
        end else begin
            overrun_q <= drop;
            if (launch_slot || launch_cmd) begin
                adr_q <= launch_slot ? p_adr : address;
                dat_q <= launch_slot ? p_dat : data_wr;
                sel_q <= launch_slot ? p_sel : selection;
                we_q  <= launch_slot ? p_we  : write;
                cyc_q <= 1'b1;
                cnt   <= '0;
            end else if (bus_end) begin
                cyc_q <= 1'b0;
                // Without ack or err the cycle can only have timed out
                err_q <= wb.wb_err_i || !wb.wb_ack_i;
                if (wb.wb_ack_i && !wb.wb_err_i && !we_q)
                    rd_q <= wb.wb_dat_i;
            end else if (state == BUS) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // One-deep pending command slot
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            p_valid <= 1'b0;
            p_adr   <= '0;
            p_dat   <= '0;
            p_sel   <= '0;
            p_we    <= 1'b0;
        end else if (capture) begin
            p_valid <= 1'b1;
            p_adr   <= address;
            p_dat   <= data_wr;
            p_sel   <= selection;
            p_we    <= write;
        end else if (launch_slot) begin
            p_valid <= 1'b0;
        end
    end

    assign done    = (state == DONE);
    assign err     = done && err_q;
    assign overrun = overrun_q;
    assign active  = (state != IDLE) || p_valid;
    assign data_rd = rd_q;

    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_sel_o = sel_q;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = cyc_q;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: write, read, queueing/overrun,
// timeout, ack+err collision and mid-cycle reset.
module tb_wb_cmd_master;
    logic        wb_clk = 1'b0;
    logic        wb_rst;
    logic        start;
    logic [31:0] address;
    logic [3:0]  selection;
    logic        write;
    logic [31:0] data_wr;
    logic [31:0] data_rd;
    logic        active, done, err, overrun;

    int tests_run = 0;
    int failed    = 0;

    wb_cmd_master_if #(.AW(32), .DW(32)) bus ();

    wb_cmd_master #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .wb_clk    (wb_clk),
        .wb_rst    (wb_rst),
        .start     (start),
        .address   (address),
        .selection (selection),
        .write     (write),
        .data_wr   (data_wr),
        .data_rd   (data_rd),
        .active    (active),
        .done      (done),
        .err       (err),
        .overrun   (overrun),
        .wb        (bus)
    );

    always #5 wb_clk = ~wb_clk;

    // Step past the next rising edge; inputs change and outputs are read here
    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic cmd(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
        start     = 1'b1;
        write     = w;
        address   = a;
        data_wr   = d;
        selection = s;
    endtask

    task automatic test_reset();
        wb_rst = 1'b1;
        start = 1'b0; write = 1'b0; address = '0; data_wr = '0; selection = '0;
        bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_dat_i = '0;
        tick(); tick();
        wb_rst = 1'b0;
        tests_run++;
        if ({active, done, err, overrun} !== 4'b0) begin
            failed++;
            $display("FAIL reset_status got %b exp 0000", {active, done, err, overrun});
        end
        tests_run++;
        if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o} !== 3'b0) begin
            failed++;
            $display("FAIL reset_bus got %b exp 000", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o});
        end
        tests_run++;
        if (data_rd !== 32'h0 || bus.wb_adr_o !== 32'h0) begin
            failed++;
            $display("FAIL reset_data got rd=%h adr=%h exp 0", data_rd, bus.wb_adr_o);
        end
    endtask

    task automatic test_write();
        int hi;
        cmd(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'hF);
        tick();
        start = 1'b0;
        hi = 0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) bus.wb_ack_i = 1'b1;
            tests_run++;
            if (bus.wb_cyc_o !== 1'b1 || bus.wb_stb_o !== 1'b1 ||
                bus.wb_adr_o !== 32'h10 || bus.wb_dat_o !== 32'hCAFE_F00D ||
                bus.wb_sel_o !== 4'hF || bus.wb_we_o !== 1'b1 || done !== 1'b0) begin
                failed++;
                $display("FAIL wr_bus_c%0d got cyc=%b adr=%h dat=%h sel=%h we=%b done=%b",
                         c, bus.wb_cyc_o, bus.wb_adr_o, bus.wb_dat_o,
                         bus.wb_sel_o, bus.wb_we_o, done);
            end
            if (bus.wb_cyc_o === 1'b1) hi++;
            tick();
        end
        bus.wb_ack_i = 1'b0;
        tests_run++;
        if (hi != 3 || bus.wb_cyc_o !== 1'b0) begin
            failed++;
            $display("FAIL wr_cyc_len got %0d cyc_now=%b exp 3 cyc_now=0", hi, bus.wb_cyc_o);
        end
        tests_run++;
        if (done !== 1'b1 || err !== 1'b0 || active !== 1'b1) begin
            failed++;
            $display("FAIL wr_done got done=%b err=%b act=%b exp 1 0 1", done, err, active);
        end
        tests_run++;
        if (data_rd !== 32'h0) begin
            failed++;
            $display("FAIL wr_rd_keep got %h exp 00000000", data_rd);
        end
        tick();
        tests_run++;
        if (done !== 1'b0 || active !== 1'b0) begin
            failed++;
            $display("FAIL wr_idle got done=%b act=%b exp 0 0", done, active);
        end
    endtask

    task automatic test_read();
        cmd(1'b0, 32'h0000_0020, 32'h0, 4'hF);
        tick();
        start = 1'b0;
        bus.wb_ack_i = 1'b1;
        bus.wb_dat_i = 32'h1234_5678;
        tests_run++;
        if (bus.wb_cyc_o !== 1'b1 || bus.wb_we_o !== 1'b0 ||
            bus.wb_adr_o !== 32'h20 || done !== 1'b0) begin
            failed++;
            $display("FAIL rd_bus got cyc=%b we=%b adr=%h done=%b exp 1 0 20 0",
                     bus.wb_cyc_o, bus.wb_we_o, bus.wb_adr_o, done);
        end
        tick();
        bus.wb_ack_i = 1'b0;
        tests_run++;
        if (done !== 1'b1 || err !== 1'b0 || data_rd !== 32'h1234_5678 ||
            bus.wb_cyc_o !== 1'b0) begin
            failed++;
            $display("FAIL rd_done got done=%b err=%b rd=%h cyc=%b exp 1 0 12345678 0",
                     done, err, data_rd, bus.wb_cyc_o);
        end
        tick();
        tests_run++;
        if (active !== 1'b0 || done !== 1'b0) begin
            failed++;
            $display("FAIL rd_idle got act=%b done=%b exp 0 0", active, done);
        end
    endtask

    task automatic test_back_to_back();
        cmd(1'b1, 32'h0000_0100, 32'h1111_1111, 4'h3);
        tick();
        cmd(1'b0, 32'h0000_0200, 32'h2222_2222, 4'hC);
        tick();
        cmd(1'b1, 32'h0000_0300, 32'h3333_3333, 4'h1);
        tests_run++;
        if (overrun !== 1'b0 || active !== 1'b1) begin
            failed++;
            $display("FAIL b2b_queue got ovr=%b act=%b exp 0 1", overrun, active);
        end
        tick();
        start = 1'b0;
        tests_run++;
        if (overrun !== 1'b1 || bus.wb_adr_o !== 32'h100 || bus.wb_cyc_o !== 1'b1) begin
            failed++;
            $display("FAIL b2b_overrun got ovr=%b adr=%h cyc=%b exp 1 100 1",
                     overrun, bus.wb_adr_o, bus.wb_cyc_o);
        end
        bus.wb_ack_i = 1'b1;
        tick();
        bus.wb_ack_i = 1'b0;
        tests_run++;
        if (done !== 1'b1 || bus.wb_cyc_o !== 1'b0 || overrun !== 1'b0) begin
            failed++;
            $display("FAIL b2b_gap got done=%b cyc=%b ovr=%b exp 1 0 0",
                     done, bus.wb_cyc_o, overrun);
        end
        tick();
        bus.wb_ack_i = 1'b1;
        bus.wb_dat_i = 32'hA5A5_5A5A;
        tests_run++;
        if (bus.wb_cyc_o !== 1'b1 || bus.wb_adr_o !== 32'h200 ||
            bus.wb_we_o !== 1'b0 || bus.wb_sel_o !== 4'hC || done !== 1'b0) begin
            failed++;
            $display("FAIL b2b_second got cyc=%b adr=%h we=%b sel=%h done=%b exp 1 200 0 c 0",
                     bus.wb_cyc_o, bus.wb_adr_o, bus.wb_we_o, bus.wb_sel_o, done);
        end
        tick();
        bus.wb_ack_i = 1'b0;
        tests_run++;
        if (done !== 1'b1 || data_rd !== 32'hA5A5_5A5A) begin
            failed++;
            $display("FAIL b2b_rd got done=%b rd=%h exp 1 a5a55a5a", done, data_rd);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            tests_run++;
            if (active !== 1'b0 || bus.wb_cyc_o !== 1'b0) begin
                failed++;
                $display("FAIL b2b_dropped_c%0d got act=%b cyc=%b exp 0 0",
                         c, active, bus.wb_cyc_o);
            end
        end
    endtask

    task automatic test_timeout();
        int hi;
        cmd(1'b0, 32'h0000_0300, 32'h0, 4'hF);
        bus.wb_dat_i = 32'hFFFF_0000;
        tick();
        start = 1'b0;
        hi = 0;
        while (bus.wb_cyc_o === 1'b1 && hi < 40) begin
            hi++;
            tick();
        end
        tests_run++;
        if (hi != 16) begin
            failed++;
            $display("FAIL to_len got %0d exp 16", hi);
        end
        tests_run++;
        if (done !== 1'b1 || err !== 1'b1 || data_rd !== 32'hA5A5_5A5A) begin
            failed++;
            $display("FAIL to_done got done=%b err=%b rd=%h exp 1 1 a5a55a5a",
                     done, err, data_rd);
        end
        tick();
        tests_run++;
        if (err !== 1'b0 || active !== 1'b0) begin
            failed++;
            $display("FAIL to_idle got err=%b act=%b exp 0 0", err, active);
        end
    endtask

    task automatic test_ack_err();
        cmd(1'b0, 32'h0000_0040, 32'h0, 4'hF);
        tick();
        start = 1'b0;
        bus.wb_ack_i = 1'b1;
        bus.wb_err_i = 1'b1;
        bus.wb_dat_i = 32'hDEAD_BEEF;
        tick();
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
        tests_run++;
        if (done !== 1'b1 || err !== 1'b1 || data_rd !== 32'hA5A5_5A5A) begin
            failed++;
            $display("FAIL ackerr got done=%b err=%b rd=%h exp 1 1 a5a55a5a",
                     done, err, data_rd);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        cmd(1'b0, 32'h0000_0400, 32'h0, 4'hF);
        tick();
        cmd(1'b1, 32'h0000_0500, 32'h5555_5555, 4'hF);
        tick();
        start = 1'b0;
        tests_run++;
        if (bus.wb_cyc_o !== 1'b1 || active !== 1'b1) begin
            failed++;
            $display("FAIL mr_busy got cyc=%b act=%b exp 1 1", bus.wb_cyc_o, active);
        end
        wb_rst = 1'b1;
        tick();
        wb_rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tests_run++;
            if (bus.wb_cyc_o !== 1'b0 || active !== 1'b0 || done !== 1'b0) begin
                failed++;
                $display("FAIL mr_c%0d got cyc=%b act=%b done=%b exp 0 0 0",
                         c, bus.wb_cyc_o, active, done);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_timeout();
        test_ack_err();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
